// File: rtl/regfile_sb.sv
// DLX decode-stage integer register file with write-through bypass, optional
// hardwired-zero r0 and a per-register pending-load scoreboard driving stall.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic [WIDTH-1:0] busA,
  output logic [WIDTH-1:0] busB,
  input  logic             wrenable,
  input  logic [AW-1:0]    rw,
  input  logic [WIDTH-1:0] busW,
  input  logic             issue,
  input  logic [AW-1:0]    issue_rd,
  output logic             stall,
  output logic [DEPTH-1:0] pending
);

  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] sb_q;
  logic [DEPTH-1:0] sb_d;
  logic             wr_hit;
  logic             hz1;
  logic             hz2;

  function automatic logic addr_valid(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  function automatic logic addr_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // wr_hit marks a write that really lands, so only those are bypassed.
  always_comb begin
    wr_hit = wrenable && addr_valid(rw) && !addr_zero(rw);
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[rw] = busW;
    end
  end

  always_comb begin
    busA = '0;
    if (addr_valid(rs1) && !addr_zero(rs1)) begin
      if (wr_hit && (rw == rs1)) begin
        busA = busW;
      end else begin
        busA = regs_q[rs1];
      end
    end
  end

  always_comb begin
    busB = '0;
    if (addr_valid(rs2) && !addr_zero(rs2)) begin
      if (wr_hit && (rw == rs2)) begin
        busB = busW;
      end else begin
        busB = regs_q[rs2];
      end
    end
  end

  // Clear is applied before set so an issue in the same cycle as a write wins.
  always_comb begin
    sb_d = sb_q;
    if (wrenable && addr_valid(rw)) begin
      sb_d[rw] = 1'b0;
    end
    if (issue && addr_valid(issue_rd) && !addr_zero(issue_rd)) begin
      sb_d[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    hz1     = addr_valid(rs1) && sb_q[rs1] && !(wrenable && (rw == rs1));
    hz2     = addr_valid(rs2) && sb_q[rs2] && !(wrenable && (rw == rs2));
    stall   = (use_rs1 && hz1) || (use_rs2 && hz2);
    pending = sb_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      sb_q <= '0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the DLX decode stage, with same-cycle write-through bypass, hardwired-zero r0, and a per-register pending-write scoreboard. It sits between instruction decode and the ID/EX latch. It supplies busA/busB from the rs1/rs2 fields. It raises `stall` when a source register still awaits a multi-cycle (load) result.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register and bus
- `DEPTH`, 32, number of registers; `AW = $clog2(DEPTH)` is the address width
- `ZERO_REG`, 1, when 1 r0 reads 0 and ignores writes and issues; when 0 r0 is an ordinary register

Ports:
- `clk` in 1: single clock, rising-edge
- `reset` in 1: asynchronous, active-high; clears all registers and the scoreboard
- `rs1`, `rs2` in AW: read addresses
- `use_rs1`, `use_rs2` in 1: the decoded instruction actually reads this source; gates `stall` only
- `busA`, `busB` out WIDTH: read data for rs1 and rs2
- `wrenable` in 1: writeback strobe
- `rw` in AW: writeback address
- `busW` in WIDTH: writeback data
- `issue` in 1: a long-latency writer of `issue_rd` leaves decode this cycle
- `issue_rd` in AW: destination register of that writer
- `stall` out 1: hazard on a used source register
- `pending` out DEPTH: scoreboard bit vector; bit i is register i, for debug and bench visibility

## Operation
- Storage: DEPTH x WIDTH flops `regs`, DEPTH-bit scoreboard `sb`.
- Write: on posedge, if `wrenable` and not (ZERO_REG and rw==0), `regs[rw] <= busW`.
- Read, combinational:
  - busA = 0 if ZERO_REG and rs1==0.
  - Otherwise busA = busW if wrenable and rw==rs1.
  - Otherwise busA = regs[rs1].
  - busB is identical using rs2.
- Bypass applies only to addresses that would actually be written. A write to r0 with ZERO_REG=1 never bypasses.
- Scoreboard update per posedge:
  - `wrenable` clears sb[rw].
  - `issue` sets sb[issue_rd].
  - If both target the same register in one cycle, set wins and the bit stays 1.
  - With ZERO_REG=1, sb[0] is never set.
- Re-issue to a register that is already pending leaves it pending. The next write clears it; there is no counting.
- stall = (use_rs1 and hz1) or (use_rs2 and hz2), combinational.
  - hz1 = sb[rs1] and not (wrenable and rw==rs1), and likewise hz2 for rs2.
  - A result arriving this cycle is bypassed instead of stalling.
- `stall` does not gate `issue`. The upstream hazard unit must hold `issue` low while stalled. This block does not check that.
- Addresses >= DEPTH (non-power-of-two DEPTH) read 0. Writes and issues to them are ignored.

## Timing
- Read and bypass latency: 0 cycles (combinational from rs*/rw/busW/wrenable).
- Write latency: 1 cycle. The value is visible from regs on the cycle after the strobe, and through bypass on the strobe cycle itself.
- Scoreboard: a set or clear on edge N is visible in `pending`/`stall` after edge N.
- Reset values: all regs 0, sb 0. Therefore busA=busB=0, stall=0, pending=0 while reset is high.
- Reset takes effect immediately, not at the next edge. It overrides any simultaneous write or issue.
- Reset asserted mid-operation discards in-flight pending bits. A write arriving after reset deassertion behaves as a normal write.
- No handshake. All inputs are sampled every cycle, and `wrenable`/`issue` are single-cycle strobes.

## Test plan
- Reset then read: assert reset, with rs1=3, rs2=7 -> busA=0, busB=0, stall=0, pending=0. Release reset, read r1..r31 -> all 0.
- Write and bypass: wrenable=1, rw=1, busW=1, rs1=1 -> busA=1 in the same cycle. Next cycle with wrenable=0 -> busA=1 from storage.
- r0 protection (ZERO_REG=1): wrenable=1, rw=0, busW=32'hDEADBEEF, rs1=0 -> busA=0 that cycle and the next. issue with issue_rd=0 -> pending[0]=0.
- Load hazard, in order:
  - issue=1, issue_rd=5 -> pending[5]=1 next cycle.
  - Then rs2=5, use_rs2=1 -> stall=1.
  - With use_rs2=0 -> stall=0.
  - Later wrenable=1, rw=5, busW=5 -> stall=0 and busB=5 in that cycle, and pending[5]=0 after the edge.
- Simultaneous set/clear: pending[2]=1; same cycle wrenable=1, rw=2 and issue=1, issue_rd=2 -> pending[2] stays 1 and regs[2] is updated.
- Async reset mid-hazard: pending[5]=1, stall=1. Pulse reset between clock edges -> stall and pending drop immediately, and regs[2] reads 0.
- Parametrisation: rerun the hazard scenario with WIDTH=64, DEPTH=16, ZERO_REG=0. The same behaviour is required, and r0 is writable (write 9, read back 9).
